// File: rtl/simplez_core.sv
// Simplez accumulator core: full eight-opcode ISA over a ready-handshaked single-port bus.
// Optional single-step mode (step input, WAIT state) is built when SIMPLEZ_STEP_EN is defined.
module simplez_core #(
  parameter int unsigned AW       = 9,
  parameter int unsigned RESET_PC = 0
) (
  input  logic          clk,
  input  logic          rstn,
`ifdef SIMPLEZ_STEP_EN
  input  logic          step,
`endif
  output logic [AW-1:0] mem_addr,
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW+2:0] mem_wdata,
  input  logic [AW+2:0] mem_rdata,
  input  logic          mem_ready,
  output logic [AW+2:0] ac_out,
  output logic [AW-1:0] pc_out,
  output logic          zflag,
  output logic          stop
);

  localparam int unsigned DW = AW + 3;
  localparam logic [AW-1:0] ResetPc = AW'(RESET_PC);

  typedef enum logic [2:0] {
    OpSt   = 3'd0,
    OpLd   = 3'd1,
    OpAdd  = 3'd2,
    OpBr   = 3'd3,
    OpBz   = 3'd4,
    OpClr  = 3'd5,
    OpDec  = 3'd6,
    OpHalt = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StOper,
`ifdef SIMPLEZ_STEP_EN
    StWait,
`endif
    StHalted
  } state_e;

  // State entered after reset and after every completed instruction.
`ifdef SIMPLEZ_STEP_EN
  localparam state_e StNext = StWait;
`else
  localparam state_e StNext = StFetch;
`endif

  state_e        state_q, state_d;
  logic [AW-1:0] cp_q, cp_d;
  logic [DW-1:0] ri_q, ri_d;
  logic [DW-1:0] ac_q, ac_d;
  logic          z_q, z_d;

  op_e           op;
  logic [AW-1:0] cd;

  assign op = op_e'(ri_q[DW-1:AW]);
  assign cd = ri_q[AW-1:0];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StNext;
      cp_q    <= ResetPc;
      ri_q    <= '0;
      ac_q    <= '0;
      z_q     <= 1'b1;
    end else begin
      state_q <= state_d;
      cp_q    <= cp_d;
      ri_q    <= ri_d;
      ac_q    <= ac_d;
      z_q     <= z_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cp_d    = cp_q;
    ri_d    = ri_q;
    ac_d    = ac_q;
    z_d     = z_q;
    unique case (state_q)
      StFetch: begin
        if (mem_ready) begin
          ri_d    = mem_rdata;
          cp_d    = cp_q + AW'(1);
          state_d = StDecode;
        end
      end
      StDecode: begin
        state_d = StNext;
        unique case (op)
          OpBr: cp_d = cd;
          OpBz: begin
            if (z_q) cp_d = cd;
          end
          OpClr: begin
            ac_d = '0;
            z_d  = 1'b1;
          end
          OpDec: begin
            ac_d = ac_q - DW'(1);
            z_d  = (ac_d == '0);
          end
          OpHalt: state_d = StHalted;
          default: state_d = StOper;
        endcase
      end
      StOper: begin
        if (mem_ready) begin
          state_d = StNext;
          if (op == OpLd) ac_d = mem_rdata;
          if (op == OpAdd) ac_d = ac_q + mem_rdata;
          if (op != OpSt) z_d = (ac_d == '0);
        end
      end
`ifdef SIMPLEZ_STEP_EN
      StWait: begin
        if (step) state_d = StFetch;
      end
`endif
      default: state_d = state_q;
    endcase
  end

  // Strobes are gated by rstn so a reset mid-access drops them in the same cycle.
  always_comb begin
    mem_re   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = cd;
    if (state_q == StFetch) begin
      mem_addr = cp_q;
      mem_re   = rstn;
    end else if (state_q == StOper) begin
      mem_re = rstn && (op != OpSt);
      mem_we = rstn && (op == OpSt);
    end
  end

  assign mem_wdata = ac_q;
  assign ac_out    = ac_q;
  assign pc_out    = cp_q;
  assign zflag     = z_q;
  assign stop      = (state_q == StHalted);

endmodule
